// File: rtl/data_bus_bridge_pkg.sv
// Shared definitions for the data-side Wishbone bridge: state encodings and bus widths.
// Optional watchdog is enabled by defining DATA_BUS_WATCHDOG_EN.
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package data_bus_bridge_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    DBB_IDLE       = 2'd0,
    DBB_BUSY       = 2'd1,
    DBB_WAIT_STALL = 2'd2
  } dbb_state_e;

endpackage

// File: rtl/data_bus_bridge_if.sv
// Wishbone B4 classic signal bundle between the data bridge (master) and the system bus (slave).
interface data_bus_bridge_if;
  import data_bus_bridge_pkg::*;

  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [WB_SEL_W-1:0] wb_sel_o;
  logic [WB_ADR_W-1:0] wb_adr_o;
  logic [WB_DAT_W-1:0] wb_dat_o;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/data_bus_bridge_bus_watchdog.sv
// Access timeout counter: cleared when a bus cycle starts, counts unterminated BUSY cycles.
// Only instantiated when DATA_BUS_WATCHDOG_EN is defined.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_term,
  output logic o_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic          w_hit;

  assign w_hit     = (r_count == CW'(TIMEOUT_CYCLES));
  assign o_timeout = w_hit;

  // Counter parks at the limit so the timeout stays visible until the FSM leaves BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_busy && !i_term && !w_hit) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/data_bus_bridge.sv
// Data-side bus master: turns MEM's combinational request into a registered Wishbone
// classic cycle, stalling the pipeline until termination. Watchdog: DATA_BUS_WATCHDOG_EN.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [WB_SEL_W-1:0] mem_sel_i,
  input  logic [WB_ADR_W-1:0] mem_addr_i,
  input  logic [WB_DAT_W-1:0] mem_data_i,
  output logic [WB_DAT_W-1:0] mem_rdata_o,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                bus_err_o,
  data_bus_bridge_if.master   wb
);

  dbb_state_e          r_state;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_DAT_W-1:0] r_rd_buf;
  logic                r_bus_err;

  logic w_accept;
  logic w_timeout;
  logic w_term;
  logic w_fail;
  logic w_unused_addr;

  assign w_unused_addr = ^mem_addr_i[1:0];

  assign w_accept = (r_state == DBB_IDLE) && mem_ce_i && (mem_sel_i != '0) && !flush_i;

`ifdef DATA_BUS_WATCHDOG_EN
  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_busy   (r_state == DBB_BUSY),
    .i_term   (wb.wb_ack_i | wb.wb_err_i),
    .o_timeout(w_timeout)
  );
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  // A timeout is treated exactly like a slave error.
  assign w_fail = wb.wb_err_i | w_timeout;
  assign w_term = wb.wb_ack_i | w_fail;

  always_comb begin
    stall_req_o = 1'b0;
    mem_rdata_o = `ZeroWord;
    case (r_state)
      DBB_IDLE: begin
        stall_req_o = w_accept;
      end
      DBB_BUSY: begin
        if (!flush_i) begin
          stall_req_o = !w_term;
          if (wb.wb_ack_i && !w_fail) begin
            mem_rdata_o = wb.wb_dat_i;
          end
        end
      end
      DBB_WAIT_STALL: begin
        mem_rdata_o = r_rd_buf;
      end
      default: begin
        stall_req_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DBB_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= `ZeroWord;
      r_dat     <= `ZeroWord;
      r_rd_buf  <= `ZeroWord;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        DBB_IDLE: begin
          if (w_accept) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= mem_we_i;
            r_sel   <= mem_sel_i;
            r_adr   <= {mem_addr_i[WB_ADR_W-1:2], 2'b00};
            r_dat   <= mem_data_i;
            r_state <= DBB_BUSY;
          end
        end
        DBB_BUSY: begin
          // Flush wins over a same-cycle ack/err: abort silently, keep rd_buf.
          if (flush_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= DBB_IDLE;
          end else if (w_term) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_rd_buf  <= w_fail ? `ZeroWord : wb.wb_dat_i;
            r_bus_err <= w_fail;
            r_state   <= stall_i ? DBB_WAIT_STALL : DBB_IDLE;
          end
        end
        DBB_WAIT_STALL: begin
          if (flush_i || !stall_i) begin
            r_state <= DBB_IDLE;
          end
        end
        default: begin
          r_state <= DBB_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_stb;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign bus_err_o   = r_bus_err;

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Data-side bus master between the MEM stage and the system Wishbone bus. It converts MEM's single-cycle combinational memory request (ce/we/sel/addr/data) into a registered Wishbone B4 classic cycle. It holds the pipeline with a stall request until the slave acknowledges, and returns read data to MEM. Pipeline flushes from the exception unit abort the access.

## Interface
- TIMEOUT_CYCLES, 255: cycles without ack/err before abort (only with watchdog compiled in)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (rst == 0 resets)
- mem_ce_i  in  1  request valid, from MEM
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte lanes; 4'b0000 = misaligned/no access
- mem_addr_i  in  32  physical byte address
- mem_data_i  in  32  write data (lanes replicated by MEM)
- mem_rdata_o  out  32  read data to MEM's mem_data_i
- stall_i  in  1  pipeline held by another stage (from ctrl)
- flush_i  in  1  exception flush (from ctrl)
- stall_req_o  out  1  stall request to ctrl
- bus_err_o  out  1  one-cycle pulse, access ended by err/timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
- wb_sel_o  out  4  byte selects
- wb_adr_o  out  32  address, bits [1:0] forced 0
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  slave read data
- wb_ack_i, wb_err_i  in  1  slave terminate

## Operation
- States: IDLE, BUSY, WAIT_STALL (2-bit, registered).
- IDLE: mem_ce_i && mem_sel_i != 0 && !flush_i → latch we/sel/adr/dat onto wb_* registers, assert cyc/stb, go BUSY. stall_req_o = 1 combinationally in this cycle.
- IDLE with mem_ce_i && mem_sel_i == 0: no bus cycle, mem_rdata_o = 0, stall_req_o = 0.
- BUSY: stall_req_o = !(wb_ack_i | wb_err_i).
  - On ack: drop cyc/stb next edge. mem_rdata_o = wb_dat_i this cycle; data captured into rd_buf.
  - On err: same as ack, but mem_rdata_o = 0 and bus_err_o pulses the next cycle.
  - Next state: WAIT_STALL if stall_i, else IDLE.
- WAIT_STALL: mem_rdata_o = rd_buf, stall_req_o = 0, no new request accepted. Returns to IDLE when stall_i falls.
- flush_i in any state: next state IDLE, cyc/stb dropped at next edge, rd_buf untouched, stall_req_o = 0 that cycle, bus_err_o not raised.
- flush_i takes priority over ack/err in the same cycle.
- mem_rdata_o is 0 in IDLE when no request is made.

## Timing
- Reset: state IDLE; wb_cyc_o/stb_o/we_o = 0; wb_sel_o = 0; wb_adr_o/dat_o = 0; rd_buf = 0; bus_err_o = 0; stall_req_o = 0; mem_rdata_o = 0.
- Reset asserted mid-BUSY drops cyc/stb immediately (asynchronous).
- Minimum access: request cycle T0, stb high T1, ack in T1 → stall_req_o high only in T0. Latency is 1 + slave wait states.
- Wishbone addr/data/sel stay stable from stb rise until the terminating cycle.
- Back-to-back: after an ack with IDLE next, a new request may start in the very next cycle.

## Configuration
- DATA_BUS_WATCHDOG_EN defined: a counter clears on entering BUSY and increments each BUSY cycle without ack/err. When it reaches TIMEOUT_CYCLES, the access terminates exactly as wb_err_i does (rdata 0, bus_err_o pulse).
- DATA_BUS_WATCHDOG_EN undefined: no counter; BUSY waits indefinitely; TIMEOUT_CYCLES is unused.

## Structure
- Shared defines: state encodings (DBB_IDLE/DBB_BUSY/DBB_WAIT_STALL), Wishbone width constants, reuse of `ZeroWord.
- One sub-module, bus_watchdog (counter + compare, instantiated only under DATA_BUS_WATCHDOG_EN). Everything else stays in one module.

## Test plan
- LW read, addr 0x0000_0104, sel 1111, ack after 2 wait states → stall_req_o high 3 cycles, mem_rdata_o = 0xDEAD_BEEF in ack cycle, wb_adr_o = 0x104.
- SB write, addr 0x0000_0203, sel 1000, data 0x5A5A_5A5A, zero-wait ack → one stall cycle, wb_we_o = 1, wb_sel_o = 1000, wb_adr_o = 0x200.
- Read with ack while stall_i = 1 for 3 cycles → WAIT_STALL holds mem_rdata_o = rd_buf value 0x1234_5678 and stall_req_o = 0 until stall_i falls, then IDLE.
- flush_i asserted in 2nd BUSY cycle → cyc/stb low next edge, bus_err_o stays 0, late ack ignored, next request proceeds normally.
- mem_ce_i = 1, sel 0000 → no cyc, stall_req_o = 0, mem_rdata_o = 0; wb_err_i in BUSY → mem_rdata_o = 0, bus_err_o single-cycle pulse.
- With DATA_BUS_WATCHDOG_EN and TIMEOUT_CYCLES = 8, no ack → abort after 8 BUSY cycles with bus_err_o pulse; rst low mid-BUSY → all outputs 0 immediately.
